spk_train_buffer: RTL and testbench
===================================

// Module: spk_train_buffer
// PURPOSE
// - Receiving end of the dense/conv core spike output. Captures each spk_arr burst
//   flagged by new_spk_train_ready, stores it by (time step, out channel), and then
//   hands the full frame set to the next layer through the pre_syn_RAM_loaded handshake.
// - Sits between one core's thresholding outputs and the next core's input fmap reader.
// PARAMETERS
// - TIME_STEPS         3   time steps per inference
// - OUT_CHANNELS       16  output channels of the producing core
// - FRAME_WIDTH        6   frame side; each spike word is FRAME_WIDTH*FRAME_WIDTH bits
// - PE_ARRAY_ROW_SIZE  2   spike words delivered per new_spk_train_ready pulse
// PORTS
// - clk                  in   1    rising-edge clock
// - rst_n                in   1    asynchronous active-low reset
// - new_spk_train_ready  in   1    1-cycle pulse: spk_arr/prev_* valid this cycle
// - prev_time_step       in   $clog2(TIME_STEPS)+1    time step of the current burst
// - prev_oc_phase        in   $clog2(OUT_CHANNELS)+1  oc phase of the current burst
// - spk_arr              in   [FW*FW-1:0] x PE_ARRAY_ROW_SIZE  spike words, row r = oc phase*ROWS+r
// - post_syn_RAM_loaded  in   1    producer pulse: last burst of the inference issued
// - pre_syn_RAM_loaded   out  1    level: buffer full, consumer may read
// - rd_en                in   1    read request
// - rd_time_step         in   $clog2(TIME_STEPS)+1    read address, time step
// - rd_oc                in   $clog2(OUT_CHANNELS)+1  read address, out channel
// - rd_data              out  FW*FW    spike word; valid 1 cycle after rd_en
// - rd_valid             out  1    qualifies rd_data
// - consumed             in   1    consumer pulse: done with buffer, release it
// - overrun              out  1    sticky error flag
// BEHAVIOUR
// - Reset (async, rst_n=0): FSM=EMPTY, pre_syn_RAM_loaded=0, rd_valid=0, rd_data=0,
//   overrun=0, all pending flags cleared. Storage contents are not reset.
// - Storage: TIME_STEPS*OUT_CHANNELS words with one write port and one read port;
//   addr = t*OUT_CHANNELS + oc.
// - Capture: on a pulse, latch all ROWS words and both indices into a staging register. Then
//   write one word per cycle, r=0..ROWS-1, at oc = prev_oc_phase*ROWS + r. A burst occupies
//   the write port for ROWS cycles.
// - FSM: EMPTY -> FILL on the first pulse. FILL -> DRAIN when post_syn_RAM_loaded is seen
//   (it is latched and may coincide with the last pulse). DRAIN -> FULL once the staging
//   writes complete. In FULL, pre_syn_RAM_loaded=1 from the cycle after the last write.
//   FULL -> EMPTY on consumed: pre_syn_RAM_loaded drops the next cycle.
// - A pulse that arrives while staging is still writing: overrun<=1 and the new burst is dropped.
//   The producer's inter-burst gap of at least 27 cycles makes this an error case only.
// - A pulse or post_syn_RAM_loaded that arrives in FULL: dropped, overrun<=1, state unchanged.
// - consumed outside FULL is ignored. overrun is cleared only by reset.
// - Out-of-range indices (t>=TIME_STEPS or oc>=OUT_CHANNELS): the write is suppressed and
//   overrun<=1. An out-of-range read returns rd_data=0 with rd_valid=1.
// - Reads are legal in any state. A read of an address being written in the same cycle
//   returns the old data.
// - Reset mid-FILL: the partial frame is discarded and the FSM returns to EMPTY.
// CONFIGURATION
// - SPK_COUNT_EN defined: adds output spk_count [$clog2(TS*OC*FW*FW)+1 bits]. It
//   accumulates the popcount of every word written, holds while FULL, and clears on
//   consumed and on reset.
// - SPK_COUNT_EN undefined: no port and no counter logic.
// TESTING
// - Reset then 8 bursts for t=0, oc phases 0..7, spk_arr[0]=36'h1, [1]=36'h2 -> after
//   16 write cycles, reads (0,0)=1 and (0,1)=2. pre_syn_RAM_loaded stays 0.
// - Full 3x8 bursts with post_syn_RAM_loaded on the last -> pre_syn_RAM_loaded=1 exactly
//   ROWS cycles later. All 48 words read back correctly with rd_valid 1 cycle after rd_en.
// - Burst while FULL -> overrun=1, stored data unchanged. consumed -> pre_syn_RAM_loaded=0
//   the next cycle, and a new fill proceeds with overrun still 1.
// - Two pulses 1 cycle apart -> the second is dropped, overrun=1, first burst stored intact.
// - rst_n low mid-FILL (after 3 bursts) -> all outputs are at reset values; a subsequent
//   full fill completes normally.
// - SPK_COUNT_EN: 48 words each 36'hF -> spk_count=192 in FULL; 0 after consumed.

Source files
------------

// File: rtl/spk_train_buffer.sv
// spk_train_buffer: captures spike bursts by (time step, out channel) and hands the full frame set to the next layer.
// Optional SPK_COUNT_EN adds a spk_count output accumulating the popcount of every stored word.
module spk_train_buffer #(
  parameter int TIME_STEPS        = 3,
  parameter int OUT_CHANNELS      = 16,
  parameter int FRAME_WIDTH       = 6,
  parameter int PE_ARRAY_ROW_SIZE = 2
) (
  input  logic                                                        clk,
  input  logic                                                        rst_n,
  input  logic                                                        new_spk_train_ready,
  input  logic [$clog2(TIME_STEPS):0]                                 prev_time_step,
  input  logic [$clog2(OUT_CHANNELS):0]                               prev_oc_phase,
  input  logic [PE_ARRAY_ROW_SIZE-1:0][FRAME_WIDTH*FRAME_WIDTH-1:0]   spk_arr,
  input  logic                                                        post_syn_RAM_loaded,
  output logic                                                        pre_syn_RAM_loaded,
  input  logic                                                        rd_en,
  input  logic [$clog2(TIME_STEPS):0]                                 rd_time_step,
  input  logic [$clog2(OUT_CHANNELS):0]                               rd_oc,
  output logic [FRAME_WIDTH*FRAME_WIDTH-1:0]                          rd_data,
  output logic                                                        rd_valid,
  input  logic                                                        consumed,
  output logic                                                        overrun
`ifdef SPK_COUNT_EN
  ,
  output logic [$clog2(TIME_STEPS*OUT_CHANNELS*FRAME_WIDTH*FRAME_WIDTH):0] spk_count
`endif
);
  localparam int TW    = $clog2(TIME_STEPS) + 1;
  localparam int OW    = $clog2(OUT_CHANNELS) + 1;
  localparam int W     = FRAME_WIDTH * FRAME_WIDTH;
  localparam int DEPTH = TIME_STEPS * OUT_CHANNELS;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = (PE_ARRAY_ROW_SIZE > 1) ? $clog2(PE_ARRAY_ROW_SIZE) : 1;
  localparam int XW    = OW + RW;
  localparam logic [TW-1:0] TS_L = TW'(TIME_STEPS);
  localparam logic [OW-1:0] OC_O = OW'(OUT_CHANNELS);
  localparam logic [XW-1:0] OC_X = XW'(OUT_CHANNELS);

  typedef enum logic [1:0] {EMPTY, FILL, DRAIN, FULL} state_t;
  state_t state, state_nx;

  logic [W-1:0]                            mem [DEPTH];
  logic [PE_ARRAY_ROW_SIZE-1:0][W-1:0]     stg_data;
  logic [TW-1:0]                           stg_t;
  logic [OW-1:0]                           stg_ph;
  logic [RW-1:0]                           stg_idx;
  logic                                    stg_busy;
  logic                                    accept, drop, last_wr, wr_ok, rd_ok;
  logic [XW-1:0]                           wr_oc;
  logic [AW-1:0]                           wr_addr, rd_addr;

  // A new burst is only taken while the staging register is idle and the buffer is not handed off
  assign accept  = new_spk_train_ready && !stg_busy && state != FULL;
  assign drop    = new_spk_train_ready && (stg_busy || state == FULL);
  assign last_wr = stg_busy && stg_idx == RW'(PE_ARRAY_ROW_SIZE - 1);
  assign wr_oc   = XW'(stg_ph) * XW'(PE_ARRAY_ROW_SIZE) + XW'(stg_idx);
  assign wr_ok   = stg_busy && stg_t < TS_L && wr_oc < OC_X;
  assign wr_addr = AW'(stg_t) * AW'(OUT_CHANNELS) + AW'(wr_oc);
  assign rd_ok   = rd_time_step < TS_L && rd_oc < OC_O;
  assign rd_addr = AW'(rd_time_step) * AW'(OUT_CHANNELS) + AW'(rd_oc);
  assign pre_syn_RAM_loaded = state == FULL;

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   state_nx = accept ? (post_syn_RAM_loaded ? DRAIN : FILL) : EMPTY;
      FILL:    state_nx = post_syn_RAM_loaded ? DRAIN : FILL;
      DRAIN:   state_nx = ((!stg_busy || last_wr) && !accept) ? FULL : DRAIN;
      default: state_nx = consumed ? EMPTY : FULL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stg_busy <= 1'b0;
      stg_idx  <= '0;
      stg_t    <= '0;
      stg_ph   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      overrun  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_ok ? mem[rd_addr] : '0;
      if (accept) begin
        stg_busy <= 1'b1;
        stg_idx  <= '0;
        stg_t    <= prev_time_step;
        stg_ph   <= prev_oc_phase;
      end else if (last_wr) stg_busy <= 1'b0;
      if (stg_busy && !last_wr) stg_idx <= stg_idx + RW'(1);
      if (drop || (stg_busy && !wr_ok) || (state == FULL && post_syn_RAM_loaded)) overrun <= 1'b1;
    end

  // Storage and staging payload carry no reset
  always_ff @(posedge clk) begin
    if (accept) stg_data <= spk_arr;
    if (wr_ok) mem[wr_addr] <= stg_data[stg_idx];
  end

`ifdef SPK_COUNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) spk_count <= '0;
    else if (state == FULL && consumed) spk_count <= '0;
    else if (wr_ok) spk_count <= spk_count + $bits(spk_count)'($countones(stg_data[stg_idx]));
`endif
endmodule

// File: tb/tb_spk_train_buffer.sv
// tb_spk_train_buffer: scenario tasks with a read-data scoreboard checked against a bench-side storage model.
module tb_spk_train_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic new_spk_train_ready = 1'b0, post_syn_RAM_loaded = 1'b0, rd_en = 1'b0, consumed = 1'b0;
  logic [2:0] prev_time_step = '0, rd_time_step = '0;
  logic [4:0] prev_oc_phase = '0, rd_oc = '0;
  logic [1:0][35:0] spk_arr = '0;
  logic pre_syn_RAM_loaded, rd_valid, overrun;
  logic [35:0] rd_data;
`ifdef SPK_COUNT_EN
  logic [11:0] spk_count;
`endif

  int tests = 0, fails = 0;
  logic [35:0] model [48];
  logic [35:0] sb [$];
  int ra_t [$], ra_o [$];

  always #5 clk = ~clk;

  spk_train_buffer dut (
    .clk(clk), .rst_n(rst_n), .new_spk_train_ready(new_spk_train_ready),
    .prev_time_step(prev_time_step), .prev_oc_phase(prev_oc_phase), .spk_arr(spk_arr),
    .post_syn_RAM_loaded(post_syn_RAM_loaded), .pre_syn_RAM_loaded(pre_syn_RAM_loaded),
    .rd_en(rd_en), .rd_time_step(rd_time_step), .rd_oc(rd_oc), .rd_data(rd_data),
    .rd_valid(rd_valid), .consumed(consumed), .overrun(overrun)
`ifdef SPK_COUNT_EN
    , .spk_count(spk_count)
`endif
  );

  function automatic logic [35:0] wd(input int t, input int oc, input int s);
    return {4'hA, 8'(s), 8'(t), 16'(oc * 257 + t * 13 + 1)};
  endfunction

  task automatic burst(input int t, input int ph, input logic [35:0] w0, input logic [35:0] w1,
                       input bit post, input bit keep, input int gap);
    @(posedge clk); #1;
    new_spk_train_ready = 1'b1; post_syn_RAM_loaded = post;
    prev_time_step = 3'(t); prev_oc_phase = 5'(ph);
    spk_arr[0] = w0; spk_arr[1] = w1;
    @(posedge clk); #1;
    new_spk_train_ready = 1'b0; post_syn_RAM_loaded = 1'b0;
    if (keep && t < 3 && ph < 8) begin
      model[t * 16 + ph * 2] = w0;
      model[t * 16 + ph * 2 + 1] = w1;
    end
    repeat (gap) @(posedge clk);
  endtask

  task automatic fill_all(input int s, input bit ones);
    for (int t = 0; t < 3; t++)
      for (int ph = 0; ph < 8; ph++) begin
        bit last = (t == 2 && ph == 7);
        burst(t, ph, ones ? 36'hF : wd(t, 2 * ph, s), ones ? 36'hF : wd(t, 2 * ph + 1, s), last, 1'b1, last ? 0 : 2);
      end
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic pulse_consumed;
    @(posedge clk); #1 consumed = 1'b1;
    @(posedge clk); #1 consumed = 1'b0;
  endtask

  task automatic queue_all;
    for (int t = 0; t < 3; t++)
      for (int o = 0; o < 16; o++) begin ra_t.push_back(t); ra_o.push_back(o); end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests += 4;
    if (pre_syn_RAM_loaded !== 1'b0) begin fails++; $display("FAIL reset_pre: got %b want 0", pre_syn_RAM_loaded); end
    if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    if (rd_data !== 36'h0) begin fails++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
`ifdef SPK_COUNT_EN
    tests++;
    if (spk_count !== 12'd0) begin fails++; $display("FAIL reset_spk_count: got %0d want 0", spk_count); end
`endif
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_readback;
    int n = ra_t.size();
    logic [35:0] e;
    for (int k = 0; k <= n; k++) begin
      @(posedge clk); #1;
      rd_en = k < n;
      if (k < n) begin
        rd_time_step = 3'(ra_t[k]);
        rd_oc = 5'(ra_o[k]);
        sb.push_back((ra_t[k] < 3 && ra_o[k] < 16) ? model[ra_t[k] * 16 + ra_o[k]] : 36'h0);
      end
      @(negedge clk);
      if (k > 0) begin
        e = sb.pop_front();
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
          fails++;
          $display("FAIL readback t=%0d oc=%0d: got valid=%b data=%h want valid=1 data=%h",
                   ra_t[k - 1], ra_o[k - 1], rd_valid, rd_data, e);
        end
      end
    end
    @(negedge clk);
    tests++;
    if (rd_valid !== 1'b0) begin fails++; $display("FAIL readback_idle: rd_valid got %b want 0", rd_valid); end
    ra_t.delete(); ra_o.delete();
  endtask

  task automatic check_ready_timing(input string name);
    @(negedge clk);
    tests++;
    if (pre_syn_RAM_loaded !== 1'b0) begin fails++; $display("FAIL %s_early0: pre got %b want 0", name, pre_syn_RAM_loaded); end
    @(negedge clk);
    tests++;
    if (pre_syn_RAM_loaded !== 1'b0) begin fails++; $display("FAIL %s_early1: pre got %b want 0", name, pre_syn_RAM_loaded); end
    @(negedge clk);
    tests++;
    if (pre_syn_RAM_loaded !== 1'b1) begin fails++; $display("FAIL %s_ready: pre got %b want 1", name, pre_syn_RAM_loaded); end
  endtask

  task automatic test_partial_fill;
    for (int ph = 0; ph < 8; ph++) burst(0, ph, 36'h1, 36'h2, 1'b0, 1'b1, 2);
    @(negedge clk);
    tests += 2;
    if (pre_syn_RAM_loaded !== 1'b0) begin fails++; $display("FAIL partial_pre: got %b want 0", pre_syn_RAM_loaded); end
    if (overrun !== 1'b0) begin fails++; $display("FAIL partial_overrun: got %b want 0", overrun); end
    ra_t = '{0, 0, 0, 0}; ra_o = '{0, 1, 14, 15};
    test_readback();
  endtask

  task automatic test_full_fill;
    do_reset();
    fill_all(1, 1'b0);
    check_ready_timing("full_fill");
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL full_overrun_clear: got %b want 0", overrun); end
    queue_all();
    ra_t.push_back(3); ra_o.push_back(0);
    ra_t.push_back(0); ra_o.push_back(16);
    ra_t.push_back(7); ra_o.push_back(31);
    test_readback();
  endtask

  task automatic test_full_overrun;
    burst(0, 0, '1, '1, 1'b0, 1'b0, 1);
    @(negedge clk);
    tests += 2;
    if (overrun !== 1'b1) begin fails++; $display("FAIL full_burst_overrun: got %b want 1", overrun); end
    if (pre_syn_RAM_loaded !== 1'b1) begin fails++; $display("FAIL full_burst_pre: got %b want 1", pre_syn_RAM_loaded); end
    @(posedge clk); #1 post_syn_RAM_loaded = 1'b1;
    @(posedge clk); #1 post_syn_RAM_loaded = 1'b0;
    @(negedge clk);
    tests++;
    if (pre_syn_RAM_loaded !== 1'b1) begin fails++; $display("FAIL full_post_pre: got %b want 1", pre_syn_RAM_loaded); end
    ra_t = '{0, 0, 2}; ra_o = '{0, 1, 15};
    test_readback();
    pulse_consumed();
    @(negedge clk);
    tests++;
    if (pre_syn_RAM_loaded !== 1'b0) begin fails++; $display("FAIL consumed_pre: got %b want 0", pre_syn_RAM_loaded); end
    fill_all(2, 1'b0);
    check_ready_timing("refill");
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL refill_overrun_sticky: got %b want 1", overrun); end
    ra_t = '{0, 1, 2}; ra_o = '{0, 7, 15};
    test_readback();
    pulse_consumed();
  endtask

  task automatic test_out_of_range;
    do_reset();
    burst(3, 0, 36'h5, 36'h6, 1'b0, 1'b0, 3);
    @(negedge clk);
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL oor_time_overrun: got %b want 1", overrun); end
    do_reset();
    burst(0, 8, 36'h5, 36'h6, 1'b0, 1'b0, 3);
    @(negedge clk);
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL oor_oc_overrun: got %b want 1", overrun); end
    ra_t = '{0, 0}; ra_o = '{0, 1};
    test_readback();
  endtask

  task automatic test_back_to_back;
    do_reset();
    @(posedge clk); #1;
    new_spk_train_ready = 1'b1; prev_time_step = 3'd1; prev_oc_phase = 5'd2;
    spk_arr[0] = 36'h1234_5678A; spk_arr[1] = 36'hBCDE_F0123;
    @(posedge clk); #1;
    prev_oc_phase = 5'd3; spk_arr[0] = 36'h0; spk_arr[1] = 36'h0;
    @(posedge clk); #1;
    new_spk_train_ready = 1'b0;
    model[20] = 36'h1234_5678A; model[21] = 36'hBCDE_F0123;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
    ra_t = '{1, 1, 1, 1}; ra_o = '{4, 5, 6, 7};
    test_readback();
  endtask

  task automatic test_reset_mid_fill;
    do_reset();
    for (int ph = 0; ph < 3; ph++) burst(2, ph, wd(2, 2 * ph, 3), wd(2, 2 * ph + 1, 3), 1'b0, 1'b1, 2);
    ra_t = '{2}; ra_o = '{1};
    test_readback();
    burst(2, 3, 36'h7, 36'h7, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    #2;
    tests += 4;
    if (pre_syn_RAM_loaded !== 1'b0) begin fails++; $display("FAIL midrst_pre: got %b want 0", pre_syn_RAM_loaded); end
    if (rd_valid !== 1'b0) begin fails++; $display("FAIL midrst_rd_valid: got %b want 0", rd_valid); end
    if (rd_data !== 36'h0) begin fails++; $display("FAIL midrst_rd_data: got %h want 0", rd_data); end
    if (overrun !== 1'b0) begin fails++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
    @(posedge clk); #1 rst_n = 1'b1;
    fill_all(4, 1'b0);
    check_ready_timing("post_reset_fill");
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL post_reset_overrun: got %b want 0", overrun); end
    ra_t = '{2, 2, 0, 1}; ra_o = '{0, 6, 5, 9};
    test_readback();
    pulse_consumed();
  endtask

`ifdef SPK_COUNT_EN
  task automatic test_spk_count;
    do_reset();
    fill_all(0, 1'b1);
    check_ready_timing("count_fill");
    @(negedge clk);
    tests++;
    if (spk_count !== 12'd192) begin fails++; $display("FAIL spk_count_full: got %0d want 192", spk_count); end
    pulse_consumed();
    @(negedge clk);
    tests++;
    if (spk_count !== 12'd0) begin fails++; $display("FAIL spk_count_consumed: got %0d want 0", spk_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_partial_fill();
    test_full_fill();
    test_full_overrun();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_fill();
`ifdef SPK_COUNT_EN
    test_spk_count();
`endif
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
